rca_arb_seq: RTL and testbench
==============================

# rca_arb_seq

Sequenced, shared wide adder. Two requesters share one 4-bit `rca` ripple slice through a round-robin arbiter. The block adds WIDTH-bit operands one nibble per cycle, least-significant first, holding the carry in a register between nibbles. It sits between client logic needing occasional wide adds and the single 4-bit adder datapath, so only one adder slice is needed regardless of WIDTH.

## Interface

- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥4; NIB = WIDTH/4 nibble steps.

- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_cin  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- res_cout  output  1  carry out of bit WIDTH-1.
- res_id  output  1  requester that owns the result.

## Operation

- Single `rca` instance. Its inputs are the a/b nibble at index idx and the carry register. Its outputs are S and c3.
- The FSM has three states.
  - IDLE: arbitrates and accepts one request.
  - RUN: processes one nibble per cycle.
  - DONE: presents the result until it is consumed.
- Arbitration happens in IDLE only.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not served last is granted (round-robin).
  - The last_id register resets to 1, so requester 0 wins the first tie.
- Ready generation:
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N.
  - Combinational, but only from the registered state, the valids and last_id.
  - At most one ready is high per cycle.
  - Both readies are 0 while rst_n is low.
- Accept (valid && ready at a rising edge):
  - Latch a, b and cin into internal registers; the carry register takes cin.
  - Set idx to 0, res_id to the granted requester, and last_id to the granted requester.
  - Go to RUN.
- RUN, on each edge:
  - res_sum[4*idx +: 4] takes S and the carry register takes c3.
  - When idx == NIB-1: res_cout takes c3 and the state goes to DONE. Otherwise idx increments.
- Requester inputs are ignored in RUN and DONE. Operands are held internally, so a requester may change its inputs after acceptance.
- DONE:
  - res_valid = 1, with res_sum, res_cout and res_id stable.
  - On res_valid && res_ready, go to IDLE.
  - No new acceptance happens in the same cycle as the result handshake.
- Reset values: state IDLE, idx 0, carry 0, res_valid 0, res_sum 0, res_cout 0, res_id 0, last_id 1.

## Timing

- Acceptance edge E0, then RUN edges E1..E_NIB. res_valid rises after E_NIB, i.e. NIB cycles after acceptance. For WIDTH=16, res_valid rises 4 cycles after acceptance.
- If res_ready is high when DONE is entered, res_valid is high for exactly 1 cycle. The next acceptance is possible at the following edge.
- Minimum spacing between acceptances is NIB+2 cycles.
- WIDTH=4: exactly one RUN cycle.
- res_* outputs are registered, with no combinational path from req* inputs.
- The nibble path goes through the 4-bit ripple only, so the critical path is independent of WIDTH.
- Reset asserted mid-RUN or mid-DONE:
  - The operation is aborted immediately (asynchronously) and the partial sum is discarded.
  - No res_valid is produced for the aborted operation.
  - The first operation after reset is arbitrated as after power-up.
- Simultaneous valid on both requesters while busy: both wait with ready low, and neither request is lost while the requester holds valid.

## Test plan

- WIDTH=16, requester 0: a=0x1234, b=0x4321, cin=0 -> res_valid 4 cycles after acceptance with res_sum=0x5555, res_cout=0, res_id=0.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> res_sum=0x0000, res_cout=1. Also a=0x8000, b=0x8000, cin=0 -> res_sum=0x0000, res_cout=1. Also a=0x0FFF, b=0x0001 -> res_sum=0x1000, res_cout=0.
- Tie from reset: both requesters held valid with distinct operands.
  - Expected: req0 accepted first (res_id=0), then req1 (res_id=1), then req0 again.
  - Only one ready is high per cycle, and each result matches its requester's operands.
- Backpressure: res_ready held low for 5 cycles after res_valid.
  - Expected: res_valid, res_sum, res_cout and res_id are stable, and both readies stay low.
  - Raising res_ready returns the block to IDLE at the next edge, and acceptance resumes the cycle after.
- Reset abort: rst_n pulled low after 2 RUN edges of 0x1111+0x2222.
  - Expected: all outputs go to their reset values immediately, and no res_valid appears.
  - A following 0x0001+0x0002 then yields res_sum=0x0003.
- Parameter sweep: WIDTH=4 and WIDTH=32 with random operands against a reference a+b+cin.
  - Expected: latency equals NIB, and sum/cout are correct for all vectors.

Source files
------------

// File: rtl/rca_arb_seq.sv
// rca_arb_seq: round-robin shared WIDTH-bit adder built on one 4-bit ripple slice, one nibble per cycle
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign c3 = c[4];
endmodule

module rca_arb_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx;
    logic             carry, last_id, grant, accept, last_nib, c3;
    logic [3:0]       s;

    // on a tie the requester not served last wins; a lone requester always wins
    assign grant      = (req0_valid && req1_valid) ? ~last_id : req1_valid;
    assign req0_ready = rst_n && state == IDLE && req0_valid && !grant;
    assign req1_ready = rst_n && state == IDLE && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign last_nib   = idx == IW'(NIB - 1);
    assign res_valid  = state == DONE;

    rca u_rca (
        .a  (a_q[{idx, 2'b00} +: 4]),
        .b  (b_q[{idx, 2'b00} +: 4]),
        .cin(carry),
        .s  (s),
        .c3 (c3)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = last_nib ? DONE : RUN;
            DONE:    state_nx = res_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_id   <= 1'b0;
            last_id  <= 1'b1;
        end else if (accept) begin
            a_q     <= grant ? req1_a : req0_a;
            b_q     <= grant ? req1_b : req0_b;
            carry   <= grant ? req1_cin : req0_cin;
            idx     <= '0;
            res_id  <= grant;
            last_id <= grant;
        end else if (state == RUN) begin
            res_sum[{idx, 2'b00} +: 4] <= s;
            carry <= c3;
            if (last_nib) res_cout <= c3;
            else          idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_rca_arb_seq.sv
// tb_rca_arb_seq: directed vectors plus a transaction-level model of the shared adder
module tb_rca_arb_seq;
    logic        clk = 0, rst_n = 0, live = 0;
    logic        v0 = 0, v1 = 0, c0 = 0, c1 = 0, res_ready = 1;
    logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic        r0, r1, res_valid, res_cout, res_id;
    logic [15:0] res_sum;
    int          vectors = 0, errs = 0;

    logic        s4_v = 0, s4_c = 0, s4_r, s4_r1, s4_rv, s4_co, s4_id;
    logic [3:0]  s4_a = 0, s4_b = 0, s4_s;
    logic        s32_v = 0, s32_c = 0, s32_r, s32_r1, s32_rv, s32_co, s32_id;
    logic [31:0] s32_a = 0, s32_b = 0, s32_s;

    always #5 clk = ~clk;

    rca_arb_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
        .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_cout(res_cout), .res_id(res_id)
    );

    rca_arb_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s4_v), .req0_ready(s4_r), .req0_a(s4_a), .req0_b(s4_b), .req0_cin(s4_c),
        .req1_valid(1'b0), .req1_ready(s4_r1), .req1_a(4'h0), .req1_b(4'h0), .req1_cin(1'b0),
        .res_valid(s4_rv), .res_ready(1'b1), .res_sum(s4_s), .res_cout(s4_co), .res_id(s4_id)
    );

    rca_arb_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s32_v), .req0_ready(s32_r), .req0_a(s32_a), .req0_b(s32_b), .req0_cin(s32_c),
        .req1_valid(1'b0), .req1_ready(s32_r1), .req1_a(32'h0), .req1_b(32'h0), .req1_cin(1'b0),
        .res_valid(s32_rv), .res_ready(1'b1), .res_sum(s32_s), .res_cout(s32_co), .res_id(s32_id)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // model: an accepted request becomes a result NIB edges later, held until consumed
    int          m_left;
    logic        m_done, m_last, m_id;
    logic [16:0] m_res;
    wire         m_g    = (v0 && v1) ? !m_last : v1;
    wire         m_idle = !m_done && m_left == 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_done <= 0; m_last <= 1; m_id <= 0; m_res <= 0;
        end else if (m_done) begin
            if (res_ready) m_done <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1;
        end else if (v0 || v1) begin
            m_last <= m_g;
            m_id   <= m_g;
            m_res  <= m_g ? 17'(a1) + 17'(b1) + 17'(c1) : 17'(a0) + 17'(b0) + 17'(c0);
            m_left <= 4;
        end
    end

    always @(negedge clk) if (live) begin
        chk("req0_ready", r0, rst_n && m_idle && v0 && !m_g);
        chk("req1_ready", r1, rst_n && m_idle && v1 && m_g);
        chk("res_valid", res_valid, m_done);
        chk("res_id", res_id, m_id);
        if (m_left == 0) chk("res_sum_cout", {res_cout, res_sum}, m_res);
    end

    task automatic op(input logic id, input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] es, input logic ec);
        int n;
        if (id) begin v1 = 1; a1 = a; b1 = b; c1 = ci; end
        else    begin v0 = 1; a0 = a; b0 = b; c0 = ci; end
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (id ? r1 : r0) break;
        end
        chk("op_ready", id ? r1 : r0, 1);
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        for (n = 1; n < 20; n++) begin
            @(posedge clk); #1;
            if (res_valid) break;
        end
        chk("op_latency", n, 4);
        chk("op_sum", res_sum, es);
        chk("op_cout", res_cout, ec);
        chk("op_id", res_id, id);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        logic [4:0]  ref4;
        logic [32:0] ref32;
        int n;
        repeat (2) @(posedge clk);
        #1 rst_n = 1; live = 1;
        op(0, 16'h1234, 16'h4321, 0, 16'h5555, 0);
        op(0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1);
        op(1, 16'h8000, 16'h8000, 0, 16'h0000, 1);
        op(0, 16'h0FFF, 16'h0001, 0, 16'h1000, 0);

        do_reset();
        v0 = 1; a0 = 16'h00FF; b0 = 16'h0F01; c0 = 0;
        v1 = 1; a1 = 16'hABCD; b1 = 16'h1111; c1 = 1;
        for (int k = 0; k < 3; k++) begin
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (r0 || r1) break;
            end
            chk("tie_order", {r1, r0}, (k == 1) ? 2'b10 : 2'b01);
            if (k == 2) begin @(posedge clk); #1 v0 = 0; v1 = 0; end
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (res_valid) break;
            end
            chk("tie_sum", {res_id, res_cout, res_sum}, (k == 1) ? 18'h2BCDF : 18'h01000);
        end
        repeat (2) @(posedge clk); #1;

        res_ready = 0;
        v0 = 1; a0 = 16'h0F0F; b0 = 16'h0101; c0 = 0;
        for (n = 0; n < 20; n++) begin @(negedge clk); if (r0) break; end
        @(posedge clk); #1 v0 = 0;
        for (n = 0; n < 20; n++) begin @(posedge clk); #1; if (res_valid) break; end
        v0 = 1; v1 = 1; a1 = 16'h0003; b1 = 16'h0004; c1 = 0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", {res_valid, res_id, res_cout, res_sum}, 19'h41010);
        end
        v1 = 0; res_ready = 1;
        @(posedge clk); #1;
        chk("bp_release", {res_valid, r0}, 2'b01);
        @(posedge clk); #1 v0 = 0;
        for (n = 0; n < 20; n++) begin @(posedge clk); #1; if (res_valid) break; end
        chk("bp_next_sum", res_sum, 16'h1010);
        @(posedge clk); #1;

        v1 = 1; a1 = 16'h1111; b1 = 16'h2222; c1 = 0;
        for (n = 0; n < 20; n++) begin @(negedge clk); if (r1) break; end
        @(posedge clk); #1 v1 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 0; v1 = 1;
        #1;
        chk("abort_outs", {res_valid, res_id, res_cout, res_sum, r0, r1}, 21'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1; v1 = 0;
        op(0, 16'h0001, 16'h0002, 0, 16'h0003, 0);

        for (int i = 0; i < 8; i++) begin
            s4_a = 4'($urandom); s4_b = 4'($urandom); s4_c = 1'($urandom); s4_v = 1;
            ref4 = 5'(s4_a) + 5'(s4_b) + 5'(s4_c);
            for (n = 0; n < 20; n++) begin @(negedge clk); if (s4_r) break; end
            chk("w4_ready", s4_r, 1);
            @(posedge clk); #1 s4_v = 0;
            for (n = 1; n < 20; n++) begin @(posedge clk); #1; if (s4_rv) break; end
            chk("w4_latency", n, 1);
            chk("w4_sum", {s4_co, s4_s}, ref4);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 8; i++) begin
            s32_a = $urandom; s32_b = $urandom; s32_c = 1'($urandom); s32_v = 1;
            if (i == 0) begin s32_a = 32'hFFFFFFFF; s32_b = 32'h0; s32_c = 1; end
            ref32 = 33'(s32_a) + 33'(s32_b) + 33'(s32_c);
            for (n = 0; n < 20; n++) begin @(negedge clk); if (s32_r) break; end
            chk("w32_ready", s32_r, 1);
            @(posedge clk); #1 s32_v = 0;
            for (n = 1; n < 20; n++) begin @(posedge clk); #1; if (s32_rv) break; end
            chk("w32_latency", n, 8);
            chk("w32_sum", {s32_co, s32_s}, ref32);
            @(posedge clk); #1;
        end

        live = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
